// File: rtl/boot_load_arbiter.sv
// Boot loader / arbiter: owns RAM port and UART at power-up, loads a program received over UART, then hands both to the CPU.
// Latency: a RAM write follows the 4th byte of each word by exactly one cycle; in RUN all CPU paths are combinational passthrough.
// Backpressure: none on rx (every byte is captured); ACK/ERR byte waits for tx_busy low before pulsing tx_start.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rx_data, rx_ready            byte stream from uart_rx
//   tx_busy, tx_data, tx_start   uart_tx handshake
//   cpu_tx_*, cpu_rx_ready       CPU side of the UART (live only in RUN)
//   cpu_mem_*                    CPU RAM port (live only in RUN)
//   mem_we, mem_addr, mem_wdata  RAM port
//   cpu_hold, load_done, load_err  status / CPU reset hold
module boot_load_arbiter #(
  parameter int          ADDR_W   = 15,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic [7:0]        cpu_tx_data,
  input  logic              cpu_tx_start,
  output logic              cpu_rx_ready,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [31:0]       cpu_mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_ACK_WAIT,
    S_ACK,
    S_RUN,
    S_ERR_WAIT,
    S_ERR,
    S_ERR_HALT
  } state_t;

  // Largest accepted word count: exactly fills the RAM.
  localparam logic [32:0] MAX_LEN = 33'(1) << ADDR_W;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_idx;   // one extra bit so a full-RAM load does not wrap
  logic [31:0]       len;
  logic [31:0]       shift;
  logic              wr_pend;

  logic [31:0]       asm_word;
  logic [ADDR_W:0]   idx_nxt;
  logic              last_word;
  logic              in_run;

  assign asm_word  = {shift[23:0], rx_data};
  assign idx_nxt   = word_idx + 1'b1;
  assign last_word = (32'(idx_nxt) == len);
  assign in_run    = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      len      <= 32'd0;
      shift    <= 32'd0;
      wr_pend  <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          if (rx_ready) begin
            shift    <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              len <= asm_word;
              if (asm_word == 32'd0)
                state <= S_ACK_WAIT;
              else if ({1'b0, asm_word} > MAX_LEN)
                state <= S_ERR_WAIT;
              else
                state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          // The write cycle presents the held word; a byte arriving in the
          // same cycle still shifts in as byte 0 of the next word.
          if (wr_pend) begin
            wr_pend  <= 1'b0;
            word_idx <= idx_nxt;
          end
          if (wr_pend && last_word) begin
            state <= S_ACK_WAIT;
          end else if (rx_ready) begin
            shift    <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              wr_pend <= 1'b1;
          end
        end

        S_ACK_WAIT: if (!tx_busy) state <= S_ACK;
        S_ACK:      state <= S_RUN;
        S_RUN:      state <= S_RUN;
        S_ERR_WAIT: if (!tx_busy) state <= S_ERR;
        S_ERR:      state <= S_ERR_HALT;
        S_ERR_HALT: state <= S_ERR_HALT;
        default:    state <= S_HDR;
      endcase
    end
  end

  // Output muxing: CPU owns everything in RUN, the loader otherwise.
  always_comb begin
    mem_we       = wr_pend;
    mem_addr     = word_idx[ADDR_W-1:0];
    mem_wdata    = shift;
    tx_start     = 1'b0;
    tx_data      = shift[7:0];
    cpu_rx_ready = 1'b0;
    case (state)
      S_RUN: begin
        mem_we       = cpu_mem_we;
        mem_addr     = cpu_mem_addr;
        mem_wdata    = cpu_mem_wdata;
        tx_start     = cpu_tx_start;
        tx_data      = cpu_tx_data;
        cpu_rx_ready = rx_ready;
      end
      S_ACK: begin
        tx_start = 1'b1;
        tx_data  = ACK_BYTE;
      end
      S_ERR: begin
        tx_start = 1'b1;
        tx_data  = ERR_BYTE;
      end
      default: ;
    endcase
  end

  assign cpu_hold  = !in_run;
  assign load_done = in_run;
  assign load_err  = (state == S_ERR_HALT);

endmodule

// File: doc/boot_load_arbiter.md
Name: boot_load_arbiter

Overview:
- Owns the single-port instruction/data RAM and the UART pair at power-up.
- Holds the multicycle CPU in reset while it receives a program over UART and writes it word-by-word into RAM.
- Then sends an acknowledge byte and hands the RAM port and UART to the CPU.
- Sits between the CPU core, the RAM and the uart_tx/uart_rx instances.

Parameters:
ADDR_W, 15, word-address width of RAM port.
ACK_BYTE, 8'hAA, byte sent on successful load.
ERR_BYTE, 8'hEE, byte sent when header length exceeds 2**ADDR_W.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rx_data  in  8  byte from uart_rx
rx_ready  in  1  one-cycle pulse, rx_data valid
tx_busy  in  1  uart_tx busy
tx_data  out  8  byte to uart_tx
tx_start  out  1  one-cycle start pulse to uart_tx
cpu_tx_data  in  8  CPU transmit byte
cpu_tx_start  in  1  CPU transmit start
cpu_rx_ready  out  1  rx_ready forwarded to CPU
cpu_mem_we  in  1  CPU RAM write enable
cpu_mem_addr  in  ADDR_W  CPU RAM word address
cpu_mem_wdata  in  32  CPU RAM write data
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM word address
mem_wdata  out  32  RAM write data
cpu_hold  out  1  1 = CPU held in reset
load_done  out  1  1 = program loaded, CPU running
load_err  out  1  1 = header rejected

Behaviour:
- Reset (rst=1 at edge): state=HDR; byte_cnt=0, word_idx=0, len=0, shift=0. Outputs: cpu_hold=1, load_done=0, load_err=0, tx_start=0, mem_we=0. Reset mid-load or in RUN restarts the protocol; RAM contents untouched.
- Byte assembly (HDR, DATA): on rx_ready, shift <= {shift[23:0], rx_data} (first byte lands in [31:24], big-endian); byte_cnt increments mod 4.
- HDR: the 4th byte sets len = the assembled 32-bit word count. Next state:
  - len==0 -> ACK_WAIT with ack=ACK_BYTE.
  - len>2**ADDR_W -> ERR_WAIT.
  - otherwise -> DATA.
- DATA: the 4th byte of a word raises wr_pend. Next cycle: mem_we=1, mem_addr=word_idx[ADDR_W-1:0], mem_wdata=assembled word. Then word_idx increments.
  - When the incremented word_idx==len, go to ACK_WAIT after that write cycle.
  - Write latency: exactly 1 cycle after the rx_ready of the 4th byte.
- A byte arriving in the same cycle as the write is captured as byte 0 of the next word; it is never dropped. It is ignored only if the load has completed.
- ACK_WAIT: wait until tx_busy=0, then ACK. ACK lasts one cycle: tx_start=1, tx_data=ACK_BYTE, next state RUN.
- RUN: cpu_hold=0, load_done=1. Combinational passthrough:
  - mem_we/mem_addr/mem_wdata from the cpu_mem_* inputs.
  - tx_data/tx_start from the cpu_tx_* inputs.
  - cpu_rx_ready=rx_ready.
  - Remains in RUN until reset.
- ERR_WAIT: wait until tx_busy=0, then ERR. ERR lasts one cycle: tx_start=1, tx_data=ERR_BYTE, then ERR_HALT.
- ERR_HALT: load_err=1, cpu_hold=1, no RAM writes. rx bytes ignored until reset.
- Outside RUN:
  - cpu_rx_ready=0.
  - cpu_mem_we ignored; mem_we only from loader writes.
  - cpu_tx_start ignored.
  - mem_addr=word_idx, tx_data=last loader byte, tx_start=0 except in ACK/ERR.
- Arithmetic: word_idx is ADDR_W+1 bits, so len=2**ADDR_W loads the full RAM with no wrap. len compare is full 32-bit.

Test Plan:
- Send 00 00 00 02 | DE AD BE EF | 01 23 45 67 -> mem_we pulses at addr 0 (wdata 32'hDEADBEEF) and addr 1 (32'h01234567), each 1 cycle after the 4th byte. tx_start with 8'hAA once tx_busy=0; then cpu_hold=0, load_done=1.
- Send 00 00 00 00 -> no mem_we; ACK 8'hAA; RUN.
- Send 00 01 00 00 with ADDR_W=15 (len=65536 > 32768) -> tx 8'hEE; load_err=1, cpu_hold=1. Further bytes produce no mem_we.
- Force rx_ready on the write cycle of word 0 -> that byte appears in [31:24] of word 1; word count stays correct.
- In RUN drive cpu_mem_we=1, addr=5, wdata=32'h12345678, cpu_tx_start with 8'h41 -> identical values on the mem_* and tx_* outputs the same cycle. rx_ready is echoed on cpu_rx_ready.
- Assert rst after 6 data bytes of a 2-word load -> state HDR, cpu_hold=1. A fresh complete load then writes correctly from addr 0.
